// File: rtl/mul_share_pkg.sv
// -----------------------------------------------------------------------------
// mul_share_pkg
// Shared definitions for the shared-multiplier controller:
//   - state_e    : controller FSM states (IDLE, CALC, RESP)
//   - OPW/PRODW  : operand and product widths of the signed multiplier
//   - NREQ_DEF / IDW_DEF : default requester count and index width
//   - mul_s()    : full-precision signed OPW x OPW -> PRODW product
// Optional feature macro used by the users of this package: MUL_SHARE_RR_EN.
// -----------------------------------------------------------------------------
package mul_share_pkg;

    localparam int OPW      = 8;
    localparam int PRODW    = 16;
    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Operands are sign-extended to the product width first, so the
    // multiply is exact (-128 * -128 = 0x4000 fits without wrap).
    function automatic logic signed [PRODW-1:0] mul_s(
        input logic signed [OPW-1:0] a,
        input logic signed [OPW-1:0] b
    );
        logic signed [PRODW-1:0] ax;
        logic signed [PRODW-1:0] bx;
        ax = a;
        bx = b;
        return ax * bx;
    endfunction

endpackage

// File: rtl/mul_share_if.sv
// -----------------------------------------------------------------------------
// mul_share_if
// Request/response bundle between the ALU issue logic (master) and the
// shared-multiplier controller (slave).
//   req_valid/req_ready : per-requester valid/ready handshake (NREQ bits)
//   req_a/req_b         : signed operands, requester i at [OPW*i +: OPW]
//   rsp_valid/rsp_ready : single response handshake
//   rsp_id              : index of the requester owning rsp_product
//   rsp_product         : signed PRODW-bit product
// -----------------------------------------------------------------------------
interface mul_share_if
    import mul_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [OPW*NREQ-1:0] req_a;
    logic [OPW*NREQ-1:0] req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [PRODW-1:0]    rsp_product;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product
    );

endinterface

// File: rtl/mul_share_arb.sv
// -----------------------------------------------------------------------------
// mul_share_arb
// Combinational winner select among NREQ requesters.
//   req_valid_i : per-requester valid
//   ptr_i       : round-robin start index (only with MUL_SHARE_RR_EN)
//   grant_o     : one-hot grant (zero when nothing is valid)
//   idx_o       : encoded winner index
//   any_o       : at least one requester is valid
// Macro MUL_SHARE_RR_EN: defined -> search starts at ptr_i and wraps modulo
// NREQ; undefined -> fixed priority, lowest index wins.
// -----------------------------------------------------------------------------
module mul_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid_i,
`ifdef MUL_SHARE_RR_EN
    input  logic [IDW-1:0]  ptr_i,
`endif
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int j;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef MUL_SHARE_RR_EN
            j = (int'(ptr_i) + k) % NREQ;
`else
            j = k;
`endif
            // First valid requester in search order wins.
            if (!any_o && req_valid_i[j]) begin
                grant_o[j] = 1'b1;
                idx_o      = IDW'(j);
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// -----------------------------------------------------------------------------
// mul_share_ctrl
// Shares one combinational signed 8x8 multiplier among NREQ requesters.
// A request is granted in IDLE, its operands are registered, the multiplier
// settles for one CALC cycle on those registers, and the product is then
// registered and held on the response port (RESP) until consumed.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mul_share_if.slave (request and response handshakes)
//   busy  : high while in CALC or RESP
// Macro MUL_SHARE_RR_EN: defined -> round-robin arbitration with a pointer
// register; undefined -> fixed priority, no pointer register.
// -----------------------------------------------------------------------------
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    mul_share_if.slave bus,
    output logic       busy
);

    state_e                  state_q;
    logic signed [OPW-1:0]   op_a_q;
    logic signed [OPW-1:0]   op_b_q;
    logic [IDW-1:0]          id_q;
    logic [IDW-1:0]          rsp_id_q;
    logic signed [PRODW-1:0] rsp_product_q;
    logic                    rsp_valid_q;
    logic                    busy_q;

    logic [NREQ-1:0]         grant;
    logic [IDW-1:0]          win_idx;
    logic                    win_any;
    logic                    grant_en;
    logic signed [OPW-1:0]   win_a;
    logic signed [OPW-1:0]   win_b;
    logic signed [PRODW-1:0] prod;

`ifdef MUL_SHARE_RR_EN
    logic [IDW-1:0]          ptr_q;
    logic [IDW-1:0]          ptr_d;
`endif

    mul_share_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_valid_i (bus.req_valid),
`ifdef MUL_SHARE_RR_EN
        .ptr_i       (ptr_q),
`endif
        .grant_o     (grant),
        .idx_o       (win_idx),
        .any_o       (win_any)
    );

    // Grants are only visible in IDLE; CALC and RESP never accept.
    assign grant_en      = (state_q == IDLE) && win_any;
    assign bus.req_ready = grant_en ? grant : '0;

    assign win_a = bus.req_a[int'(win_idx)*OPW +: OPW];
    assign win_b = bus.req_b[int'(win_idx)*OPW +: OPW];

    // The single multiplier instance: driven only from the operand registers.
    assign prod = mul_s(op_a_q, op_b_q);

`ifdef MUL_SHARE_RR_EN
    assign ptr_d = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_a_q        <= '0;
            op_b_q        <= '0;
            id_q          <= '0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            rsp_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef MUL_SHARE_RR_EN
            ptr_q         <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_en) begin
                        op_a_q  <= win_a;
                        op_b_q  <= win_b;
                        id_q    <= win_idx;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
`ifdef MUL_SHARE_RR_EN
                        ptr_q   <= ptr_d;
`endif
                    end
                end
                CALC: begin
                    rsp_product_q <= prod;
                    rsp_id_q      <= id_q;
                    rsp_valid_q   <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_product_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_share_ctrl
// Self-checking bench for mul_share_ctrl. Expected products are pushed to a
// scoreboard when a grant is seen and compared when the response is consumed;
// directed sequences add timing, corner-value, contention, backpressure and
// reset checks. Honours MUL_SHARE_RR_EN for the expected grant order.
// -----------------------------------------------------------------------------
module tb_mul_share_ctrl;
    import mul_share_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [15:0]    prod;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    int nchk = 0;
    int nfail = 0;

    exp_t sb[$];

    always #5 clk = ~clk;

    mul_share_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    mul_share_ctrl #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard monitor: push on grant, pop and compare on consume.
    logic signed [7:0]  m_a;
    logic signed [7:0]  m_b;
    logic signed [15:0] m_p;
    exp_t               m_e;

    always @(negedge clk) begin
        if (rst_n) begin
            if (|bus.req_ready) begin
                chk("ready_onehot", {31'b0, $onehot(bus.req_ready)}, 32'd1);
                for (int i = 0; i < NREQ; i++) begin
                    if (bus.req_ready[i]) begin
                        m_a = bus.req_a[i*8 +: 8];
                        m_b = bus.req_b[i*8 +: 8];
                        m_p = m_a * m_b;
                        m_e.id = IDW'(i);
                        m_e.prod = m_p;
                        sb.push_back(m_e);
                    end
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk("sb_prod", {16'b0, bus.rsp_product}, {16'b0, m_e.prod});
                    chk("sb_id", {30'b0, bus.rsp_id}, {30'b0, m_e.id});
                end
            end
        end
    end

    task automatic drive(input int i, input logic [7:0] a, input logic [7:0] b, input logic v);
        bus.req_a[i*8 +: 8] = a;
        bus.req_b[i*8 +: 8] = b;
        bus.req_valid[i]    = v;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int n = 0; n < 20 && idx < 0; n++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++)
                if (bus.req_ready[i] && idx < 0) idx = i;
        end
        if (idx < 0) begin
            chk("grant_timeout", 32'd0, 32'd1);
            idx = 0;
        end
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input string tag);
        int idx;
        @(posedge clk); #1;
        drive(i, a, b, 1'b1);
        wait_grant(idx);
        chk({tag, "_gnt"}, idx, i);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
        wait_rsp();
        chk({tag, "_prod"}, {16'b0, bus.rsp_product}, {16'b0, exp_p});
        chk({tag, "_id"}, {30'b0, bus.rsp_id}, i);
    endtask

    int idx;
    int exp_order[5];
    logic [15:0] hold_p;
    logic [IDW-1:0] hold_id;

    initial begin
`ifdef MUL_SHARE_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
        chk("rst_rsp_id", {30'b0, bus.rsp_id}, 0);
        chk("rst_rsp_product", {16'b0, bus.rsp_product}, 0);
        chk("rst_req_ready", {28'b0, bus.req_ready}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_req_ready", {28'b0, bus.req_ready}, 0);
        chk("idle_busy", {31'b0, busy}, 0);

        // Single request, cycle-accurate latency
        @(posedge clk); #1;
        drive(0, 8'h05, 8'hFD, 1'b1);
        @(negedge clk);
        chk("single_T_ready", {28'b0, bus.req_ready}, 32'h1);
        chk("single_T_busy", {31'b0, busy}, 0);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        chk("single_T1_valid", {31'b0, bus.rsp_valid}, 0);
        chk("single_T1_busy", {31'b0, busy}, 1);
        @(negedge clk);
        chk("single_T2_valid", {31'b0, bus.rsp_valid}, 1);
        chk("single_T2_prod", {16'b0, bus.rsp_product}, 32'hFFF1);
        chk("single_T2_id", {30'b0, bus.rsp_id}, 0);
        @(negedge clk);
        chk("single_T3_busy", {31'b0, busy}, 0);
        chk("single_T3_valid", {31'b0, bus.rsp_valid}, 0);

        // Corner operands
        do_req(1, 8'h80, 8'h80, 16'h4000, "c_m128sq");
        do_req(3, 8'h80, 8'h7F, 16'hC080, "c_m128x127");
        do_req(0, 8'h00, 8'h9C, 16'h0000, "c_zero");

        // Backpressure: stall in RESP with a second request pending
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive(2, 8'h33, 8'hC5, 1'b1);
        wait_grant(idx);
        chk("bp_gnt", idx, 2);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        drive(1, 8'h7F, 8'h02, 1'b1);
        wait_rsp();
        hold_p  = bus.rsp_product;
        hold_id = bus.rsp_id;
        chk("bp_prod", {16'b0, hold_p}, 32'hF43F);
        chk("bp_id", {30'b0, hold_id}, 2);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, bus.rsp_valid}, 1);
            chk("bp_hold_prod", {16'b0, bus.rsp_product}, {16'b0, hold_p});
            chk("bp_hold_id", {30'b0, bus.rsp_id}, {30'b0, hold_id});
            chk("bp_hold_ready", {28'b0, bus.req_ready}, 0);
            chk("bp_hold_busy", {31'b0, busy}, 1);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_next_grant", {28'b0, bus.req_ready}, 32'h2);
        chk("bp_next_valid", {31'b0, bus.rsp_valid}, 0);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_rsp();
        chk("bp_next_prod", {16'b0, bus.rsp_product}, 32'h00FE);
        chk("bp_next_id", {30'b0, bus.rsp_id}, 1);

        // Reset during CALC
        @(posedge clk); #1;
        drive(2, 8'h11, 8'h22, 1'b1);
        wait_grant(idx);
        chk("rc_gnt", idx, 2);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        chk("rc_calc_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("rc_busy", {31'b0, busy}, 0);
        chk("rc_rsp_valid", {31'b0, bus.rsp_valid}, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("rc_no_rsp", {31'b0, bus.rsp_valid}, 0);
        end

        // Contention: all requesters held valid; first grant also shows pointer reset
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++)
            drive(i, 8'($urandom), 8'($urandom), 1'b1);
        for (int n = 0; n < 5; n++) begin
            wait_grant(idx);
            chk("cont_grant", idx, exp_order[n]);
            @(posedge clk); #1;
            if (n == 4) bus.req_valid = '0;
            else drive(idx, 8'($urandom), 8'($urandom), 1'b1);
        end
        for (int n = 0; n < 10 && sb.size() != 0; n++) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
